// File: rtl/sdram_arbit_if.sv
// Bundle between the SDRAM sub-modules (init/refresh/write/read) and the command arbiter.
// The arbiter uses the slave modport; whatever sources requests and sinks pins uses master.
interface sdram_arbit_if #(
  parameter int DATA_W = 16
);
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [1:0]        init_bank;
  logic [12:0]       init_addr;
  logic              ar_req;
  logic              ar_end;
  logic [3:0]        ar_cmd;
  logic [1:0]        ar_bank;
  logic [12:0]       ar_addr;
  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_bank;
  logic [12:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_dq_oe;
  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_bank;
  logic [12:0]       rd_addr;
  logic              ar_en;
  logic              wr_en;
  logic              rd_en;
  logic              arb_err;
  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [1:0]        sdram_ba;
  logic [12:0]       sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  modport slave (
    input  init_end, init_cmd, init_bank, init_addr,
    input  ar_req, ar_end, ar_cmd, ar_bank, ar_addr,
    input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_data, wr_dq_oe,
    input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    output ar_en, wr_en, rd_en, arb_err,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );

  modport master (
    output init_end, init_cmd, init_bank, init_addr,
    output ar_req, ar_end, ar_cmd, ar_bank, ar_addr,
    output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_data, wr_dq_oe,
    output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    input  ar_en, wr_en, rd_en, arb_err,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants refresh > write > read one at a time, muxes the
// granted module onto the pins, and forces a hung grant back to idle via a watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | power-up sequence owns the pins until init_end
// ST_IDLE  | NOP on the pins; next grant decided here
// ST_AREF  | auto-refresh granted (ar_en)
// ST_WRITE | write granted (wr_en), owns DQ
// ST_READ  | read granted (rd_en)
module sdram_arbit #(
  parameter int          DATA_W  = 16,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic          arb_clk,
  input  logic          arb_rst_n,
  sdram_arbit_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [15:0] WD_LAST  = TIMEOUT - 16'd1;

  state_t            r_state;
  state_t            w_next;
  logic              w_timeout;
  logic              w_wd_expire;
  logic [15:0]       r_wd_cnt;
  logic              r_ar_en;
  logic              r_wr_en;
  logic              r_rd_en;
  logic              r_arb_err;
  logic [3:0]        w_cmd;
  logic [1:0]        w_ba;
  logic [12:0]       w_addr;
  logic [DATA_W-1:0] w_dq_out;
  logic              w_dq_oe;

  assign w_wd_expire = (r_wd_cnt >= WD_LAST);

  // An end pulse in the expiry cycle takes precedence, so no error is flagged.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_INIT:  if (bus.init_end) w_next = ST_IDLE;
      ST_IDLE: begin
        if (bus.ar_req)      w_next = ST_AREF;
        else if (bus.wr_req) w_next = ST_WRITE;
        else if (bus.rd_req) w_next = ST_READ;
      end
      ST_AREF: begin
        if (bus.ar_end) w_next = ST_IDLE;
        else if (w_wd_expire) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_WRITE: begin
        if (bus.wr_end) w_next = ST_IDLE;
        else if (w_wd_expire) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_READ: begin
        if (bus.rd_end) w_next = ST_IDLE;
        else if (w_wd_expire) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      default:  w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      r_state   <= ST_INIT;
      r_ar_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_arb_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ar_en   <= (w_next == ST_AREF);
      r_wr_en   <= (w_next == ST_WRITE);
      r_rd_en   <= (w_next == ST_READ);
      r_arb_err <= w_timeout;
    end
  end

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state == ST_INIT || r_state == ST_IDLE) begin
      r_wd_cnt <= 16'd0;
    end else if (r_wd_cnt != 16'hffff) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  // Reset gates the mux so pins fall to NOP immediately, not at the next edge.
  always_comb begin
    w_cmd    = CMD_NOP;
    w_ba     = 2'b11;
    w_addr   = 13'h1fff;
    w_dq_out = '0;
    w_dq_oe  = 1'b0;
    if (arb_rst_n) begin
      case (r_state)
        ST_INIT: begin
          w_cmd  = bus.init_cmd;
          w_ba   = bus.init_bank;
          w_addr = bus.init_addr;
        end
        ST_AREF: begin
          w_cmd  = bus.ar_cmd;
          w_ba   = bus.ar_bank;
          w_addr = bus.ar_addr;
        end
        ST_WRITE: begin
          w_cmd    = bus.wr_cmd;
          w_ba     = bus.wr_bank;
          w_addr   = bus.wr_addr;
          w_dq_out = bus.wr_data;
          w_dq_oe  = bus.wr_dq_oe;
        end
        ST_READ: begin
          w_cmd  = bus.rd_cmd;
          w_ba   = bus.rd_bank;
          w_addr = bus.rd_addr;
        end
        default: ;
      endcase
    end
  end

  assign bus.ar_en        = r_ar_en;
  assign bus.wr_en        = r_wr_en;
  assign bus.rd_en        = r_rd_en;
  assign bus.arb_err      = r_arb_err;
  assign bus.sdram_cke    = 1'b1;
  assign bus.sdram_cs_n   = w_cmd[3];
  assign bus.sdram_ras_n  = w_cmd[2];
  assign bus.sdram_cas_n  = w_cmd[1];
  assign bus.sdram_we_n   = w_cmd[0];
  assign bus.sdram_ba     = w_ba;
  assign bus.sdram_addr   = w_addr;
  assign bus.sdram_dq_out = w_dq_out;
  assign bus.sdram_dq_oe  = w_dq_oe;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus a randomized run, all checked
// against a grant-owner model that follows the arbitration and watchdog rules.
module tb_sdram_arbit;
  localparam int          DATA_W  = 16;
  localparam logic [15:0] TIMEOUT = 16'd1000;
  localparam int O_INIT = 0, O_IDLE = 1, O_AR = 2, O_WR = 3, O_RD = 4;
  localparam logic [36:0] PINS_RST = {1'b1, 4'b0111, 2'b11, 13'h1fff, 16'h0, 1'b0};

  logic arb_clk   = 1'b0;
  logic arb_rst_n = 1'b0;
  always #5 arb_clk = ~arb_clk;

  sdram_arbit_if #(.DATA_W(DATA_W)) bus();
  sdram_arbit #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .arb_clk   (arb_clk),
    .arb_rst_n (arb_rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_owner = O_INIT;
  int m_age   = 0;
  bit m_err   = 1'b0;

  logic [36:0] act_pins;
  logic [3:0]  act_en;
  assign act_pins = {bus.sdram_cke, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n,
                     bus.sdram_we_n, bus.sdram_ba, bus.sdram_addr, bus.sdram_dq_out,
                     bus.sdram_dq_oe};
  assign act_en = {bus.ar_en, bus.wr_en, bus.rd_en, bus.arb_err};

  function automatic logic [36:0] exp_pins();
    if (!arb_rst_n) return PINS_RST;
    case (m_owner)
      O_INIT:  return {1'b1, bus.init_cmd, bus.init_bank, bus.init_addr, 16'h0, 1'b0};
      O_AR:    return {1'b1, bus.ar_cmd, bus.ar_bank, bus.ar_addr, 16'h0, 1'b0};
      O_WR:    return {1'b1, bus.wr_cmd, bus.wr_bank, bus.wr_addr, bus.wr_data, bus.wr_dq_oe};
      O_RD:    return {1'b1, bus.rd_cmd, bus.rd_bank, bus.rd_addr, 16'h0, 1'b0};
      default: return PINS_RST;
    endcase
  endfunction

  function automatic logic [3:0] exp_en();
    if (!arb_rst_n) return 4'b0000;
    return {m_owner == O_AR, m_owner == O_WR, m_owner == O_RD, m_err};
  endfunction

  // Advance the model by one clock edge using the inputs visible at that edge.
  task automatic model_edge();
    logic done;
    if (!arb_rst_n) begin
      m_owner = O_INIT; m_age = 0; m_err = 1'b0;
      return;
    end
    m_err = 1'b0;
    case (m_owner)
      O_INIT: if (bus.init_end) m_owner = O_IDLE;
      O_IDLE: begin
        m_age = 0;
        if (bus.ar_req)      m_owner = O_AR;
        else if (bus.wr_req) m_owner = O_WR;
        else if (bus.rd_req) m_owner = O_RD;
      end
      default: begin
        done = (m_owner == O_AR) ? bus.ar_end : (m_owner == O_WR) ? bus.wr_end : bus.rd_end;
        if (done) m_owner = O_IDLE;
        else if (m_age == int'(TIMEOUT) - 1) begin
          m_owner = O_IDLE; m_err = 1'b1;
        end else m_age++;
      end
    endcase
  endtask

  task automatic step();
    @(posedge arb_clk);
    model_edge();
    #1;
  endtask

  task automatic clear_ctrl();
    bus.ar_req = 0; bus.ar_end = 0; bus.wr_req = 0; bus.wr_end = 0;
    bus.rd_req = 0; bus.rd_end = 0; bus.wr_dq_oe = 0;
  endtask

  task automatic rand_payload();
    bus.init_cmd = 4'($urandom); bus.init_bank = 2'($urandom); bus.init_addr = 13'($urandom);
    bus.ar_cmd   = 4'($urandom); bus.ar_bank   = 2'($urandom); bus.ar_addr   = 13'($urandom);
    bus.wr_cmd   = 4'($urandom); bus.wr_bank   = 2'($urandom); bus.wr_addr   = 13'($urandom);
    bus.rd_cmd   = 4'($urandom); bus.rd_bank   = 2'($urandom); bus.rd_addr   = 13'($urandom);
    bus.wr_data  = 16'($urandom);
  endtask

  task automatic test_reset();
    arb_rst_n = 0; bus.init_end = 0; clear_ctrl(); rand_payload();
    bus.init_cmd = 4'b0010;
    model_edge();
    #12;
    n_cmp++;
    if (act_pins !== PINS_RST) begin
      n_bad++; $display("FAIL reset_pins actual=%h expected=%h", act_pins, PINS_RST);
    end
    n_cmp++;
    if (act_en !== 4'b0000) begin
      n_bad++; $display("FAIL reset_en actual=%b expected=0000", act_en);
    end
    @(negedge arb_clk); arb_rst_n = 1;
    for (int i = 0; i < 50; i++) begin
      rand_payload();
      step();
      n_cmp++;
      if (act_pins !== exp_pins() || act_en !== 4'b0000) begin
        n_bad++; $display("FAIL init_mux cyc=%0d actual=%h/%b expected=%h/0000",
                          i, act_pins, act_en, exp_pins());
      end
    end
    bus.init_end = 1;
    step();
    n_cmp++;
    if (act_pins !== PINS_RST || act_en !== 4'b0000) begin
      n_bad++; $display("FAIL init_to_idle actual=%h/%b expected=%h/0000", act_pins, act_en, PINS_RST);
    end
  endtask

  task automatic test_priority();
    bus.ar_req = 1; bus.wr_req = 1; bus.rd_req = 1;
    step();
    n_cmp++;
    if (act_en !== 4'b1000 || act_pins !== exp_pins()) begin
      n_bad++; $display("FAIL prio_ar actual=%b/%h expected=1000/%h", act_en, act_pins, exp_pins());
    end
    bus.ar_req = 0;
    repeat (3) step();
    bus.ar_end = 1; step(); bus.ar_end = 0;
    n_cmp++;
    if (act_en !== 4'b0000 || act_pins !== PINS_RST) begin
      n_bad++; $display("FAIL prio_gap1 actual=%b/%h expected=0000/%h", act_en, act_pins, PINS_RST);
    end
    step();
    n_cmp++;
    if (act_en !== 4'b0100 || act_pins !== exp_pins()) begin
      n_bad++; $display("FAIL prio_wr actual=%b/%h expected=0100/%h", act_en, act_pins, exp_pins());
    end
    bus.wr_req = 0;
    repeat (2) step();
    bus.wr_end = 1; step(); bus.wr_end = 0;
    n_cmp++;
    if (act_en !== 4'b0000) begin
      n_bad++; $display("FAIL prio_gap2 actual=%b expected=0000", act_en);
    end
    step();
    n_cmp++;
    if (act_en !== 4'b0010 || act_pins !== exp_pins()) begin
      n_bad++; $display("FAIL prio_rd actual=%b/%h expected=0010/%h", act_en, act_pins, exp_pins());
    end
    bus.rd_req = 0; bus.rd_end = 1; step(); bus.rd_end = 0;
    n_cmp++;
    if (act_en !== 4'b0000) begin
      n_bad++; $display("FAIL prio_rd_end actual=%b expected=0000", act_en);
    end
  endtask

  task automatic test_no_preempt();
    bus.wr_req = 1; step(); bus.wr_req = 0; bus.ar_req = 1;
    for (int i = 0; i < 8; i++) begin
      bus.wr_dq_oe = 1'($urandom); bus.wr_data = 16'($urandom);
      step();
      n_cmp++;
      if (act_en !== 4'b0100 || bus.sdram_dq_oe !== bus.wr_dq_oe || act_pins !== exp_pins()) begin
        n_bad++; $display("FAIL no_preempt cyc=%0d actual=%b/%h expected=0100/%h",
                          i, act_en, act_pins, exp_pins());
      end
    end
    bus.wr_dq_oe = 1; bus.wr_end = 1; step(); bus.wr_end = 0;
    n_cmp++;
    if (act_en !== 4'b0000 || bus.sdram_dq_oe !== 1'b0) begin
      n_bad++; $display("FAIL preempt_gap actual=%b oe=%b expected=0000 oe=0", act_en, bus.sdram_dq_oe);
    end
    step();
    n_cmp++;
    if (act_en !== 4'b1000 || bus.sdram_dq_oe !== 1'b0) begin
      n_bad++; $display("FAIL preempt_ar actual=%b oe=%b expected=1000 oe=0", act_en, bus.sdram_dq_oe);
    end
    bus.ar_req = 0; bus.wr_dq_oe = 0; bus.ar_end = 1; step(); bus.ar_end = 0;
  endtask

  task automatic test_watchdog();
    int hi = 1;
    int errs = 0;
    int k = 0;
    bus.rd_req = 1; step(); bus.rd_req = 0;
    while (bus.rd_en === 1'b1 && k < 1100) begin
      step(); k++;
      if (bus.rd_en === 1'b1) hi++;
      if (bus.arb_err === 1'b1) errs++;
      n_cmp++;
      if (act_en !== exp_en()) begin
        n_bad++; $display("FAIL wd_track cyc=%0d actual=%b expected=%b", k, act_en, exp_en());
      end
    end
    repeat (3) begin
      step();
      if (bus.arb_err === 1'b1) errs++;
    end
    n_cmp++;
    if (hi !== int'(TIMEOUT)) begin
      n_bad++; $display("FAIL wd_grant_len actual=%0d expected=%0d", hi, TIMEOUT);
    end
    n_cmp++;
    if (errs !== 1 || act_en !== 4'b0000) begin
      n_bad++; $display("FAIL wd_err_pulses actual=%0d/%b expected=1/0000", errs, act_en);
    end
  endtask

  task automatic test_end_at_last();
    bus.rd_req = 1; step(); bus.rd_req = 0;
    repeat (int'(TIMEOUT) - 1) step();
    n_cmp++;
    if (act_en !== 4'b0010) begin
      n_bad++; $display("FAIL last_cycle_grant actual=%b expected=0010", act_en);
    end
    bus.rd_end = 1; step(); bus.rd_end = 0;
    n_cmp++;
    if (act_en !== 4'b0000 || act_en !== exp_en()) begin
      n_bad++; $display("FAIL last_cycle_release actual=%b expected=0000", act_en);
    end
    step();
    n_cmp++;
    if (bus.arb_err !== 1'b0) begin
      n_bad++; $display("FAIL last_cycle_noerr actual=%b expected=0", bus.arb_err);
    end
  endtask

  task automatic test_reset_midwrite();
    bus.wr_req = 1; bus.wr_dq_oe = 1; step(); bus.wr_req = 0;
    repeat (3) step();
    bus.ar_req = 1; bus.rd_req = 1; bus.wr_req = 1;
    #2;
    arb_rst_n = 0; bus.init_end = 0;
    model_edge();
    #1;
    n_cmp++;
    if (act_en !== 4'b0000 || act_pins !== PINS_RST) begin
      n_bad++; $display("FAIL async_reset actual=%b/%h expected=0000/%h", act_en, act_pins, PINS_RST);
    end
    @(negedge arb_clk); arb_rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (act_en !== 4'b0000 || act_pins !== exp_pins()) begin
        n_bad++; $display("FAIL reinit_hold cyc=%0d actual=%b/%h expected=0000/%h",
                          i, act_en, act_pins, exp_pins());
      end
    end
    bus.init_end = 1; step();
    n_cmp++;
    if (act_en !== 4'b0000 || act_pins !== PINS_RST) begin
      n_bad++; $display("FAIL reinit_idle actual=%b/%h expected=0000/%h", act_en, act_pins, PINS_RST);
    end
    step();
    n_cmp++;
    if (act_en !== 4'b1000) begin
      n_bad++; $display("FAIL reinit_ar actual=%b expected=1000", act_en);
    end
    clear_ctrl(); bus.ar_end = 1; step(); bus.ar_end = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rand_payload();
      bus.ar_req = ($urandom_range(0, 3) == 0);
      bus.wr_req = ($urandom_range(0, 1) == 0);
      bus.rd_req = ($urandom_range(0, 1) == 0);
      bus.ar_end = ($urandom_range(0, 5) == 0);
      bus.wr_end = ($urandom_range(0, 5) == 0);
      bus.rd_end = ($urandom_range(0, 5) == 0);
      bus.wr_dq_oe = 1'($urandom);
      step();
      n_cmp++;
      if (act_en !== exp_en() || act_pins !== exp_pins()) begin
        n_bad++; $display("FAIL random cyc=%0d actual=%b/%h expected=%b/%h",
                          i, act_en, act_pins, exp_en(), exp_pins());
      end
    end
    clear_ctrl();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    test_reset();
    test_priority();
    test_no_preempt();
    test_watchdog();
    test_end_at_last();
    test_reset_midwrite();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
Command arbiter sitting directly downstream of the init, auto-refresh, write and read sub-modules of the SDRAM controller. It grants one sub-module at a time via enable signals and muxes that module's command/bank/address/data onto the SDRAM pins. Refresh has the highest priority, then write, then read. A watchdog recovers the arbiter from a hung grant.

Parameters:
DATA_W, 16, SDRAM DQ width
TIMEOUT, 16'd1000, max cycles a grant may stay open before forced release

Ports:
arb_clk  in  1  clock, 100 MHz
arb_rst_n  in  1  asynchronous active-low reset
init_end  in  1  init done, level; high from init completion onward
init_cmd  in  4  init command {CS#,RAS#,CAS#,WE#}
init_bank  in  2  init bank
init_addr  in  13  init address
ar_req  in  1  auto-refresh request
ar_end  in  1  refresh done, 1-cycle pulse
ar_cmd  in  4  refresh command
ar_bank  in  2  refresh bank
ar_addr  in  13  refresh address
wr_req  in  1  write request
wr_end  in  1  write done, 1-cycle pulse
wr_cmd  in  4  write command
wr_bank  in  2  write bank
wr_addr  in  13  write address
wr_data  in  DATA_W  write data
wr_dq_oe  in  1  write module drives DQ
rd_req  in  1  read request
rd_end  in  1  read done, 1-cycle pulse
rd_cmd  in  4  read command
rd_bank  in  2  read bank
rd_addr  in  13  read address
ar_en  out  1  refresh grant
wr_en  out  1  write grant
rd_en  out  1  read grant
arb_err  out  1  watchdog timeout, 1-cycle pulse
sdram_cke  out  1  clock enable
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
sdram_ba  out  2  bank pins
sdram_addr  out  13  address pins
sdram_dq_out  out  DATA_W  DQ output data
sdram_dq_oe  out  1  DQ output enable

Behaviour:
- Reset values: state INIT; ar_en, wr_en, rd_en, arb_err = 0; sdram_cke = 1; command NOP 4'b0111; sdram_ba = 2'b11; sdram_addr = 13'h1fff; sdram_dq_oe = 0; sdram_dq_out = 0.
- States: INIT, IDLE, AREF, WRITE, READ. State register is async reset.
- Transitions:
  - INIT -> IDLE when init_end = 1.
  - IDLE -> AREF if ar_req; else WRITE if wr_req; else READ if rd_req. Priority is evaluated in the same cycle.
  - AREF -> IDLE on ar_end; WRITE -> IDLE on wr_end; READ -> IDLE on rd_end.
  - From any grant state, go to IDLE when the watchdog expires.
- No preemption. A request arriving during another grant waits until return to IDLE; the granted module finishes its burst.
- The end pulse always passes through IDLE. The minimum gap between grants is one IDLE cycle, during which NOP is driven. The next grant is decided in that IDLE cycle.
- Enables are registered. Each is set on the edge entering its state and cleared on the edge leaving it, so ar_en == (state == AREF), etc. At most one enable is high at any time.
- Pin mux is combinational on the registered state:
  - INIT: init_*.
  - AREF: ar_*.
  - WRITE: wr_*; sdram_dq_out = wr_data; sdram_dq_oe = wr_dq_oe.
  - READ: rd_*.
  - IDLE: NOP, ba 2'b11, addr 13'h1fff.
  - sdram_dq_oe = 0 outside WRITE.
- Command split: {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = selected 4-bit cmd.
- Watchdog:
  - 16-bit counter, cleared in INIT/IDLE, incremented each cycle in a grant state.
  - When it reaches TIMEOUT-1 and no end pulse arrives that cycle: go to IDLE, pulse arb_err for 1 cycle.
  - An end pulse in the same cycle wins, with no arb_err.
  - The counter saturates and never wraps.
- Stray ar_end/wr_end/rd_end while not in the matching state is ignored.
- Reset mid-grant: return to INIT immediately, all outputs to reset values; requests are re-arbitrated only after init_end.

Test Plan:
- Reset, init_end low 50 cycles, then high -> pins equal init_* during INIT; IDLE one cycle after init_end; NOP/ba 3/addr 1fff in IDLE.
- ar_req, wr_req, rd_req all asserted in same IDLE cycle -> ar_en high next cycle, wr_en/rd_en 0; after ar_end, 1 IDLE cycle, then wr_en; after wr_end, 1 IDLE cycle, then rd_en.
- wr_req granted, ar_req rises mid-write -> wr_en stays until wr_end; ar_en rises 2 cycles after wr_end; sdram_dq_oe follows wr_dq_oe only while wr_en.
- rd_req granted, rd_end withheld -> after 1000 cycles state IDLE, rd_en 0, arb_err pulses exactly once.
- rd_end asserted exactly on cycle 999 of the grant -> normal release, arb_err stays 0.
- Assert arb_rst_n low during WRITE -> ar_en/wr_en/rd_en 0, NOP driven, dq_oe 0 asynchronously; no grant until init_end.
